memory_writer: RTL and testbench

//  Avalon-ST sink to memory write-port bridge; the write-side counterpart of the DSP memory reader.

---
 rtl/dsp_pkg.sv | 14 +
 rtl/memory_writer.sv | 167 ++++++++++++++++
 tb/tb_memory_writer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/dsp_pkg.sv
// Shared types for the DSP subsystem stream/memory bridges.
// Holds the memory_writer FSM encoding and the default frame-length ceiling.
package dsp_pkg;

    typedef enum logic [1:0] {
        MW_IDLE  = 2'd0,
        MW_WRITE = 2'd1,
        MW_DROP  = 2'd2
    } memory_writer_state_t;

    localparam int MW_ADDR_W     = 13;
    localparam int MW_MAX_POINTS = 8192;

endpackage

// File: rtl/memory_writer.sv
// Avalon-ST sink to memory write-port bridge: stores one sop..eop frame of
// samples at addresses 0..N-1 and pulses done (full frame) or error (framing fault).
module memory_writer
    import dsp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = MW_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] memory_writer_sink_data,
    input  logic              memory_writer_sink_valid,
    input  logic              memory_writer_sink_sop,
    input  logic              memory_writer_sink_eop,
    output logic              memory_writer_sink_ready,
    input  logic              memory_writer_hold,
    input  logic [ADDR_W:0]   memory_writer_number_of_points,
    output logic [ADDR_W-1:0] memory_writer_writeaddress,
    output logic              memory_writer_write,
    output logic [DATA_W-1:0] memory_writer_writedata,
    output logic              memory_writer_done,
    output logic              memory_writer_error
);

    localparam logic [ADDR_W:0] MAX_POINTS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_POINT  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] NO_POINTS  = {(ADDR_W+1){1'b0}};

    // Zero or oversize lengths mean "the whole buffer".
    function automatic logic [ADDR_W:0] clamp_points(input logic [ADDR_W:0] n);
        if ((n == NO_POINTS) || (n > MAX_POINTS)) begin
            return MAX_POINTS;
        end else begin
            return n;
        end
    endfunction

    memory_writer_state_t state_r, state_s;
    logic [ADDR_W:0]      count_r, count_s;
    logic [ADDR_W:0]      npts_r, npts_s;
    logic [ADDR_W:0]      count_inc_s;
    logic [ADDR_W:0]      npts_new_s;
    logic                 ready_s;
    logic                 accept_s;
    logic                 wr_s;
    logic [ADDR_W-1:0]    waddr_s;
    logic                 done_s;
    logic                 err_s;

    // Sink readiness: only an idle bridge honours hold, and nothing is taken in reset.
    always_comb begin
        ready_s = 1'b0;
        if (!rst_n) begin
            ready_s = 1'b0;
        end else if (state_r == MW_IDLE) begin
            ready_s = !memory_writer_hold;
        end else begin
            ready_s = 1'b1;
        end
    end

    assign memory_writer_sink_ready = ready_s;
    assign accept_s    = memory_writer_sink_valid & ready_s;
    assign count_inc_s = count_r + ONE_POINT;
    assign npts_new_s  = clamp_points(memory_writer_number_of_points);

    // Next-state and per-beat write/done/error decisions.
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        npts_s  = npts_r;
        wr_s    = 1'b0;
        waddr_s = {ADDR_W{1'b0}};
        done_s  = 1'b0;
        err_s   = 1'b0;
        if (accept_s) begin
            if (memory_writer_sink_sop) begin
                // A sop always starts a fresh frame; mid-frame it is also a fault.
                npts_s  = npts_new_s;
                wr_s    = 1'b1;
                waddr_s = {ADDR_W{1'b0}};
                count_s = ONE_POINT;
                err_s   = (state_r != MW_IDLE);
                if ((npts_new_s == ONE_POINT) || memory_writer_sink_eop) begin
                    done_s  = (npts_new_s == ONE_POINT) && memory_writer_sink_eop;
                    err_s   = err_s | (memory_writer_sink_eop && (npts_new_s > ONE_POINT));
                    state_s = MW_IDLE;
                    count_s = NO_POINTS;
                end else begin
                    state_s = MW_WRITE;
                end
            end else begin
                case (state_r)
                    MW_IDLE: begin
                        err_s = 1'b1;
                    end
                    MW_WRITE: begin
                        wr_s    = 1'b1;
                        waddr_s = count_r[ADDR_W-1:0];
                        count_s = count_inc_s;
                        if (count_inc_s == npts_r) begin
                            done_s  = 1'b1;
                            state_s = memory_writer_sink_eop ? MW_IDLE : MW_DROP;
                            count_s = NO_POINTS;
                        end else if (memory_writer_sink_eop) begin
                            err_s   = 1'b1;
                            state_s = MW_IDLE;
                            count_s = NO_POINTS;
                        end else begin
                            state_s = MW_WRITE;
                        end
                    end
                    MW_DROP: begin
                        if (memory_writer_sink_eop) begin
                            err_s   = 1'b1;
                            state_s = MW_IDLE;
                        end else begin
                            state_s = MW_DROP;
                        end
                    end
                    default: begin
                        state_s = MW_IDLE;
                        count_s = NO_POINTS;
                    end
                endcase
            end
        end else begin
            state_s = state_r;
        end
    end

    // FSM, beat counter and latched frame length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= MW_IDLE;
            count_r <= NO_POINTS;
            npts_r  <= MAX_POINTS;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            npts_r  <= npts_s;
        end
    end

    // Registered write port and status pulses, one cycle after the accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memory_writer_write        <= 1'b0;
            memory_writer_writeaddress <= {ADDR_W{1'b0}};
            memory_writer_writedata    <= {DATA_W{1'b0}};
            memory_writer_done         <= 1'b0;
            memory_writer_error        <= 1'b0;
        end else begin
            memory_writer_write <= wr_s;
            memory_writer_done  <= done_s;
            memory_writer_error <= err_s;
            if (wr_s) begin
                memory_writer_writeaddress <= waddr_s;
                memory_writer_writedata    <= memory_writer_sink_data;
            end else begin
                memory_writer_writeaddress <= memory_writer_writeaddress;
                memory_writer_writedata    <= memory_writer_writedata;
            end
        end
    end

endmodule

// File: tb/tb_memory_writer.sv
// Scoreboard bench for memory_writer: a frame-level reference model predicts
// each write/done/error, and an independent monitor checks the DUT cycle by cycle.
module tb_memory_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] sink_data;
    logic        sink_valid, sink_sop, sink_eop, sink_ready, hold;
    logic [13:0] number_of_points;
    logic [12:0] writeaddress;
    logic        write, done, error;
    logic [31:0] writedata;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct packed {
        logic        wr;
        logic [12:0] addr;
        logic [31:0] data;
        logic        done;
        logic        err;
        int          at;
    } ev_t;

    ev_t exp_q[$];

    // Reference model: is a frame open, is the tail being discarded, beats stored, frame length.
    bit m_open;
    bit m_discard;
    int m_idx;
    int m_n;

    memory_writer dut (
        .clk                            (clk),
        .rst_n                          (rst_n),
        .memory_writer_sink_data        (sink_data),
        .memory_writer_sink_valid       (sink_valid),
        .memory_writer_sink_sop         (sink_sop),
        .memory_writer_sink_eop         (sink_eop),
        .memory_writer_sink_ready       (sink_ready),
        .memory_writer_hold             (hold),
        .memory_writer_number_of_points (number_of_points),
        .memory_writer_writeaddress     (writeaddress),
        .memory_writer_write            (write),
        .memory_writer_writedata        (writedata),
        .memory_writer_done             (done),
        .memory_writer_error            (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    // Monitor: compare what the DUT presents against the next predicted event.
    always @(negedge clk) begin
        ev_t ev;
        ev = '0;
        while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
            void'(exp_q.pop_front());
            chk("missed_event", 64'd1, 64'd0);
        end
        if (exp_q.size() > 0 && exp_q[0].at == cyc) ev = exp_q.pop_front();
        chk("write", write, ev.wr);
        chk("done", done, ev.done);
        chk("error", error, ev.err);
        if (ev.wr) begin
            chk("writeaddress", writeaddress, ev.addr);
            chk("writedata", writedata, ev.data);
        end
    end

    task automatic model_reset();
        m_open = 0; m_discard = 0; m_idx = 0; m_n = 8192;
        exp_q.delete();
    endtask

    task automatic model_accept(input bit s, input bit e, input logic [31:0] d, input int np);
        ev_t ev;
        ev = '0;
        ev.at = cyc + 1;
        if (s) begin
            ev.err = m_open || m_discard;
            m_n = (np == 0 || np > 8192) ? 8192 : np;
            ev.wr = 1; ev.addr = 13'd0; ev.data = d;
            m_idx = 1; m_discard = 0;
            if (m_n == 1 || e) begin
                ev.done = (m_n == 1) && e;
                if (e && m_n > 1) ev.err = 1;
                m_open = 0;
            end else begin
                m_open = 1;
            end
        end else if (m_open) begin
            ev.wr = 1; ev.addr = 13'(m_idx); ev.data = d;
            m_idx++;
            if (m_idx == m_n) begin
                ev.done = 1; m_open = 0; m_discard = !e;
            end else if (e) begin
                ev.err = 1; m_open = 0;
            end
        end else if (m_discard) begin
            if (e) begin
                ev.err = 1; m_discard = 0;
            end
        end else begin
            ev.err = 1;
        end
        if (ev.wr || ev.done || ev.err) exp_q.push_back(ev);
    endtask

    // One clock of stimulus; predicts sink_ready from the model and scores the accept.
    task automatic drive(input bit v, input bit s, input bit e, input logic [31:0] d,
                         input bit h, input int np);
        bit exp_ready;
        @(posedge clk); #1;
        sink_valid = v; sink_sop = s; sink_eop = e; sink_data = d;
        hold = h; number_of_points = 14'(np);
        #1;
        exp_ready = rst_n && ((m_open || m_discard) ? 1'b1 : !h);
        chk("sink_ready", sink_ready, exp_ready);
        if (v && exp_ready) model_accept(s, e, d, np);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, $urandom, 0, 8);
    endtask

    task automatic send_frame(input int beats, input int np, input bit gaps,
                              input bit with_eop, input logic [15:0] lo);
        for (int i = 0; i < beats; i++) begin
            if (gaps) drive(0, 0, 0, $urandom, 0, np);
            drive(1, i == 0, with_eop && (i == beats - 1), {16'(i + 1), lo}, 0, np);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        model_reset();
        sink_valid = 0; sink_sop = 0; sink_eop = 0;
        @(negedge clk);
        chk("rst_write", write, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_ready", sink_ready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; sink_valid = 0; sink_sop = 0; sink_eop = 0;
        sink_data = '0; hold = 0; number_of_points = 14'd8;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("reset_ready", sink_ready, 1'b0);
        chk("reset_addr", writeaddress, 13'd0);
        chk("reset_data", writedata, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // contiguous 8-point frame
        send_frame(8, 8, 0, 1, 16'h0000);
        idle(3);
        // valid toggling
        send_frame(8, 8, 1, 1, 16'h1111);
        idle(3);
        // short frame, then a good one
        send_frame(5, 8, 0, 1, 16'h2222);
        send_frame(8, 8, 0, 1, 16'h3333);
        idle(2);
        // long frame: 6 beats for N=4
        send_frame(6, 4, 0, 1, 16'h4444);
        idle(2);
        // hold blocks the frame start
        for (int i = 0; i < 4; i++) drive(1, 1, 0, 32'hDEAD_0000, 1, 8);
        send_frame(8, 8, 0, 1, 16'h5555);
        idle(2);
        // stray beat outside a frame, and one-beat frames
        drive(1, 0, 1, 32'h1234_5678, 0, 8);
        drive(1, 1, 1, 32'h0BAD_0001, 0, 1);
        drive(1, 1, 1, 32'h0BAD_0002, 0, 8);
        idle(2);
        // N=0 clamps to the full 8192-entry buffer
        send_frame(8192, 0, 0, 1, 16'h6666);
        idle(2);
        // abandoned by reset at beat 100, then a fresh frame
        send_frame(100, 0, 0, 0, 16'h7777);
        do_reset();
        send_frame(8, 8, 0, 1, 16'h8888);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 5) == 0, $urandom, $urandom_range(0, 7) == 0,
                  $urandom_range(1, 12));
        end
        idle(4);
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
